// File: rtl/serial_word_feeder_pkg.sv
// ----------------------------------------------------------------------------
// serial_word_feeder_pkg
// Shared definitions for the serial word feeder:
//   state_t      - feeder FSM states (IDLE, SHIFT, FLUSH, DRAIN)
//   FILL_DEFAULT - default bit value driven on SI while flushing
//   ctr_width()  - width of the downstream edge counter. It holds at most
//                  DATAWIDTH + 2**SELWIDTH - 1 shift edges, plus one spare bit.
// ----------------------------------------------------------------------------
package serial_word_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic FILL_DEFAULT = 1'b0;

    function automatic int ctr_width(input int data_width, input int sel_width);
        return $clog2(data_width + 2**sel_width) + 1;
    endfunction

endpackage

// File: rtl/serial_word_feeder_ctr.sv
// ----------------------------------------------------------------------------
// serial_word_feeder_ctr
// Counts the downstream shift edges (cycles with clken high) of the current
// word. It flags do_valid in the cycle after edge e whenever
// SEL+1 <= e <= DATAWIDTH+SEL. In those cycles the tap DO = data[SEL] holds
// a payload bit. The counter saturates and never wraps within a word.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   clken    in   registered shift enable, as seen by the shift register
//   SEL      in   registered tap select for the current word
//   start    in   word accepted this cycle; clears the counter
//   do_valid out  registered: the downstream DO carries a payload bit
// ----------------------------------------------------------------------------
module serial_word_feeder_ctr
    import serial_word_feeder_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int SELWIDTH  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clken,
    input  logic [SELWIDTH-1:0] SEL,
    input  logic                start,
    output logic                do_valid
);

    localparam int CW = ctr_width(DATAWIDTH, SELWIDTH);
    localparam logic [CW-1:0] EMAX = '1;

    logic [CW-1:0] e;
    logic [CW-1:0] e_next;
    logic [CW-1:0] win_lo;
    logic [CW-1:0] win_hi;

    // The window is tested against the post-edge count, so do_valid is
    // registered into the cycle that follows edge e.
    always_comb begin
        e_next = (e == EMAX) ? e : e + CW'(1);
        win_lo = CW'(SEL) + CW'(1);
        win_hi = CW'(SEL) + CW'(DATAWIDTH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e        <= '0;
            do_valid <= 1'b0;
        end else if (start) begin
            e        <= '0;
            do_valid <= 1'b0;
        end else if (clken) begin
            e        <= e_next;
            do_valid <= (e_next >= win_lo) && (e_next <= win_hi);
        end else begin
            do_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_feeder.sv
// ----------------------------------------------------------------------------
// serial_word_feeder
// Accepts parallel words over a valid/ready handshake and serialises each one
// onto SI/clken for a downstream variable-tap shift register (DO = data[SEL]).
// After the payload it shifts SEL fill bits, so every payload bit reaches DO.
// It then spends one DRAIN cycle and pulses done. Throughput is one word per
// DATAWIDTH + SEL + 2 cycles.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   in_valid  in   upstream word valid
//   in_ready  out  feeder can accept a word
//   in_data   in   payload word [DATAWIDTH-1:0]
//   in_sel    in   tap select for this word [SELWIDTH-1:0]
//   SI        out  serial bit to the shift register
//   clken     out  shift enable to the shift register
//   SEL       out  tap select, constant for the whole word
//   do_valid  out  downstream DO holds a payload bit this cycle
//   done      out  one-cycle pulse when the last payload bit is on DO
//
// Build option:
//   SERIAL_WORD_FEEDER_LSB_FIRST_EN - when defined, in_data[0] is shifted
//   first. When undefined (default), in_data[DATAWIDTH-1] is shifted first.
// ----------------------------------------------------------------------------
module serial_word_feeder
    import serial_word_feeder_pkg::*;
#(
    parameter int   DATAWIDTH = 8,
    parameter int   SELWIDTH  = 3,
    parameter logic FILL      = FILL_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic [SELWIDTH-1:0]  in_sel,
    output logic                 SI,
    output logic                 clken,
    output logic [SELWIDTH-1:0]  SEL,
    output logic                 do_valid,
    output logic                 done
);

    localparam int CW = ctr_width(DATAWIDTH, SELWIDTH);

    state_t               state;
    logic [DATAWIDTH-1:0] shreg;
    logic [CW-1:0]        left;
    logic                 accept;
    logic                 first_bit;
    logic                 next_bit;
    logic [DATAWIDTH-1:0] in_rest;
    logic [DATAWIDTH-1:0] sh_rest;

    assign accept = (state == IDLE) && in_valid && in_ready;

    // The first bit goes straight to SI on the accept edge. shreg keeps only
    // the bits still to send, with the next one at the outgoing end.
`ifdef SERIAL_WORD_FEEDER_LSB_FIRST_EN
    assign first_bit = in_data[0];
    assign in_rest   = in_data >> 1;
    assign next_bit  = shreg[0];
    assign sh_rest   = shreg >> 1;
`else
    assign first_bit = in_data[DATAWIDTH-1];
    assign in_rest   = in_data << 1;
    assign next_bit  = shreg[DATAWIDTH-1];
    assign sh_rest   = shreg << 1;
`endif

    // 'left' counts the cycles still to go in the current SHIFT or FLUSH
    // phase after this one. It is loaded on entry to each phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            left     <= '0;
            in_ready <= 1'b0;
            SI       <= 1'b0;
            clken    <= 1'b0;
            SEL      <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= SHIFT;
                        shreg    <= in_rest;
                        SEL      <= in_sel;
                        left     <= CW'(DATAWIDTH - 1);
                        in_ready <= 1'b0;
                        SI       <= first_bit;
                        clken    <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (left != '0) begin
                        left  <= left - CW'(1);
                        SI    <= next_bit;
                        shreg <= sh_rest;
                    end else if (SEL != '0) begin
                        state <= FLUSH;
                        left  <= CW'(SEL) - CW'(1);
                        SI    <= FILL;
                    end else begin
                        state <= DRAIN;
                        SI    <= 1'b0;
                        clken <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (left != '0) begin
                        left <= left - CW'(1);
                    end else begin
                        state <= DRAIN;
                        SI    <= 1'b0;
                        clken <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DRAIN: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    serial_word_feeder_ctr #(
        .DATAWIDTH (DATAWIDTH),
        .SELWIDTH  (SELWIDTH)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .clken    (clken),
        .SEL      (SEL),
        .start    (accept),
        .do_valid (do_valid)
    );

endmodule

// File: tb/tb_serial_word_feeder.sv
// ----------------------------------------------------------------------------
// tb_serial_word_feeder
// Self-checking bench for serial_word_feeder (DATAWIDTH=8, SELWIDTH=3,
// FILL=0). A per-word phase model gives the expected outputs for every cycle.
// A model of the downstream shift register (DO = data[SEL]) checks the
// payload bit presented on each do_valid cycle. Directed words pin the model
// to hand-computed values, followed by randomised words.
// ----------------------------------------------------------------------------
module tb_serial_word_feeder;

    localparam int   DW       = 8;
    localparam int   SW       = 3;
    localparam int   DEPTH    = 1 << SW;
    localparam logic FILL_BIT = 1'b0;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic [SW-1:0] in_sel   = '0;
    logic          in_ready;
    logic          SI;
    logic          clken;
    logic [SW-1:0] SEL;
    logic          do_valid;
    logic          done;

    int checks = 0;
    int errors = 0;

    serial_word_feeder #(
        .DATAWIDTH (DW),
        .SELWIDTH  (SW),
        .FILL      (FILL_BIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .SI       (SI),
        .clken    (clken),
        .SEL      (SEL),
        .do_valid (do_valid),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Position in the word of payload bit k, which is shifted k-th.
    function automatic int bit_pos(input int k);
`ifdef SERIAL_WORD_FEEDER_LSB_FIRST_EN
        return k;
`else
        return DW - 1 - k;
`endif
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: m_pos is the cycle number inside the current word
    // (1 = cycle after accept, 0 = idle). m_ready is the expected in_ready.
    int            cyc             = 0;
    int            m_pos           = 0;
    logic          m_ready         = 1'b0;
    logic [DW-1:0] m_word          = '0;
    int            m_sel           = 0;
    int            accept_cyc      = 0;
    int            prev_accept_cyc = 0;
    int            accept_count    = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pos   = 0;
            m_ready = 1'b0;
        end else begin
            cyc++;
            if (m_pos == 0) begin
                if (m_ready && in_valid) begin
                    m_word          = in_data;
                    m_sel           = int'(in_sel);
                    m_pos           = 1;
                    m_ready         = 1'b0;
                    prev_accept_cyc = accept_cyc;
                    accept_cyc      = cyc;
                    accept_count++;
                end else begin
                    m_ready = 1'b1;
                end
            end else if (m_pos == DW + m_sel + 1) begin
                m_pos   = 0;
                m_ready = 1'b1;
            end else begin
                m_pos++;
            end
        end
    end

    // Downstream shift register; bit 0 receives SI on each enabled edge.
    logic [DEPTH-1:0] ds_reg = '0;

    always @(posedge clk) begin
        if (clken) ds_reg <= {ds_reg[DEPTH-2:0], SI};
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    logic [DW-1:0] collected  = '0;
    logic [DW-1:0] last_word  = '0;
    int            done_seen  = 0;
    int            done_cycle = 0;
    logic          first_si   = 1'b0;

    always @(negedge clk) begin
        int   c;
        int   k;
        logic exp_clken;
        logic exp_si;
        logic exp_dv;
        logic exp_done;
        if (!rst) begin
            check_output("reset_outputs", 32'({in_ready, SI, clken, do_valid, done, SEL}), 32'(0));
        end else begin
            c         = m_pos;
            exp_clken = (c >= 1) && (c <= DW + m_sel);
            if (c >= 1 && c <= DW)
                exp_si = m_word[bit_pos(c - 1)];
            else if (c > DW && c <= DW + m_sel)
                exp_si = FILL_BIT;
            else
                exp_si = 1'b0;
            exp_dv    = (c >= m_sel + 2) && (c <= DW + m_sel + 1);
            exp_done  = (c == DW + m_sel + 1);
            check_output("ctrl_outputs", 32'({in_ready, SI, clken, do_valid, done}),
                         32'({m_ready, exp_si, exp_clken, exp_dv, exp_done}));
            if (c >= 1) check_output("sel_hold", 32'(SEL), 32'(m_sel));
            if (c == 1) begin
                collected = '0;
                first_si  = SI;
            end
            if (exp_dv) begin
                k = c - (m_sel + 2);
                check_output("do_bit", 32'(ds_reg[SEL]), 32'(m_word[bit_pos(k)]));
                collected[bit_pos(k)] = ds_reg[SEL];
            end
            if (done) begin
                last_word  = collected;
                done_cycle = cyc - accept_cyc + 1;
                done_seen++;
            end
        end
    end

    task automatic wait_accept(input int target);
        int n = 0;
        while (accept_count < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (accept_count < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got %0d accepts, expected %0d", accept_count, target);
        end
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_seen < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done_seen < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got %0d done pulses, expected %0d", done_seen, target);
        end
    endtask

    // Offer one word, scramble the inputs once it is taken, and wait for done.
    task automatic apply_stimulus(input logic [DW-1:0] word, input logic [SW-1:0] sel);
        int a0 = accept_count;
        int d0 = done_seen;
        in_valid = 1'b1;
        in_data  = word;
        in_sel   = sel;
        wait_accept(a0 + 1);
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_sel   = SW'($urandom);
        wait_done(d0 + 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0;
        int d0;
        logic [DW-1:0] w;
        logic [SW-1:0] s;

        $display("[TB] starting serial_word_feeder bench");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_output("ready_before_edge", 32'(in_ready), 32'(0));
        @(negedge clk);
        check_output("ready_after_edge", 32'(in_ready), 32'(1));

        // MSB-first 8'hA5 with sel 3: done in cycle 12
        apply_stimulus(8'hA5, 3'd3);
        check_output("t1_word", 32'(last_word), 32'hA5);
        check_output("t1_done_cycle", 32'(done_cycle), 32'd12);

        // sel 0 skips FLUSH: done in cycle 9, 10 cycles per word
        apply_stimulus(8'h3C, 3'd0);
        check_output("t2_word", 32'(last_word), 32'h3C);
        check_output("t2_done_cycle", 32'(done_cycle), 32'd9);

        // maximum tap select
        apply_stimulus(8'h81, 3'd7);
        check_output("t3_word", 32'(last_word), 32'h81);
        check_output("t3_done_cycle", 32'(done_cycle), 32'd16);

        // back-to-back words; in_data changes while the first word is busy
        a0 = accept_count;
        d0 = done_seen;
        in_valid = 1'b1;
        in_data  = 8'hF0;
        in_sel   = 3'd2;
        wait_accept(a0 + 1);
        in_data  = 8'h0F;
        wait_accept(a0 + 2);
        in_valid = 1'b0;
        check_output("t4_spacing", 32'(accept_cyc - prev_accept_cyc), 32'd12);
        check_output("t4_first_word", 32'(last_word), 32'hF0);
        wait_done(d0 + 2);
        check_output("t4_second_word", 32'(last_word), 32'h0F);
        @(negedge clk);

        // reset in the 4th SHIFT cycle drops the word
        a0 = accept_count;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        in_sel   = 3'd4;
        wait_accept(a0 + 1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_output("t5_async_clear", 32'({in_ready, SI, clken, do_valid, done, SEL}), 32'(0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_output("t5_ready_low", 32'(in_ready), 32'(0));
        @(negedge clk);
        check_output("t5_ready_high", 32'(in_ready), 32'(1));
        apply_stimulus(8'h55, 3'd5);
        check_output("t5_word", 32'(last_word), 32'h55);

        // single set bit shows the shift order
        apply_stimulus(8'h01, 3'd1);
        check_output("t6_word", 32'(last_word), 32'h01);
`ifdef SERIAL_WORD_FEEDER_LSB_FIRST_EN
        check_output("t6_first_si", 32'(first_si), 32'(1));
`else
        check_output("t6_first_si", 32'(first_si), 32'(0));
`endif

        // randomised words with random idle gaps
        for (int i = 0; i < 40; i++) begin
            w = DW'($urandom);
            s = SW'($urandom_range(0, 7));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                in_data = DW'($urandom);
                @(negedge clk);
            end
            apply_stimulus(w, s);
            check_output("rand_word", 32'(last_word), 32'(w));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
